// File: rtl/fetch_unit_if.sv
// Shared fetch packet type and the fetch <-> I-cache request/response bus.
// The fetch unit drives the request side (master); the cache drives the
// response side (slave).

package fetch_unit_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } FETCH_PACKET;

endpackage

interface fetch_unit_if #(
  parameter int PUSH_WIDTH = 4
);

  logic                    icache_req_valid;
  logic                    icache_req_ready;
  logic [31:0]             icache_req_addr;
  logic                    icache_req_epoch;
  logic                    icache_resp_valid;
  logic [32*PUSH_WIDTH-1:0] icache_resp_data;
  logic                    icache_resp_epoch;

  modport master (
    output icache_req_valid,
    output icache_req_addr,
    output icache_req_epoch,
    input  icache_req_ready,
    input  icache_resp_valid,
    input  icache_resp_data,
    input  icache_resp_epoch
  );

  modport slave (
    input  icache_req_valid,
    input  icache_req_addr,
    input  icache_req_epoch,
    output icache_req_ready,
    output icache_resp_valid,
    output icache_resp_data,
    output icache_resp_epoch
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: keeps the fetch PC, issues one aligned block request at a
// time, holds the returned block until the instruction buffer has enough
// free slots, then pushes the lanes from the fetch PC onward as compacted
// fetch packets. Redirects squash in-flight work through a 1-bit epoch.

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          PUSH_WIDTH  = 4,
  parameter int          IB_IDX_BITS = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IB_IDX_BITS:0]          available_slots,
  output FETCH_PACKET [PUSH_WIDTH-1:0]  new_ib_entries,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  fetch_unit_if.master                  icache
);

  localparam int          LANE_BITS = $clog2(PUSH_WIDTH);
  localparam int          BLK_BITS  = LANE_BITS + 2;
  localparam int          CNT_W     = LANE_BITS + 1;
  localparam logic [31:0] BLK_BYTES = 32'(PUSH_WIDTH * 4);
  localparam logic [31:0] BLK_MASK  = BLK_BYTES - 32'd1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                   state_r;
  logic [31:0]              fetch_pc_r;
  logic                     epoch_r;
  logic [32*PUSH_WIDTH-1:0] hold_data_r;
  logic [31:0]              hold_base_r;
  logic [LANE_BITS-1:0]     hold_first_r;

  logic [31:0]              block_base_s;
  logic [CNT_W-1:0]         cnt_s;
  logic                     push_s;

  // Block address, lane count of the held block, and the push decision.
  always_comb begin
    block_base_s = fetch_pc_r & ~BLK_MASK;
    cnt_s        = CNT_W'(PUSH_WIDTH) - CNT_W'(hold_first_r);
    if (!reset && (state_r == S_HOLD) && !redirect_valid &&
        (32'(available_slots) >= 32'(cnt_s))) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Request strobe: only in FETCH, suppressed by reset and by a redirect.
  always_comb begin
    icache.icache_req_addr  = block_base_s;
    icache.icache_req_epoch = epoch_r;
    if (!reset && (state_r == S_FETCH) && !redirect_valid) begin
      icache.icache_req_valid = 1'b1;
    end else begin
      icache.icache_req_valid = 1'b0;
    end
  end

  // Push bundle: lanes first..PUSH_WIDTH-1 compacted into entries 0..cnt-1.
  always_comb begin
    new_ib_entries = '0;
    for (int j = 0; j < PUSH_WIDTH; j++) begin
      if (push_s && (j < int'(cnt_s))) begin
        new_ib_entries[j].valid = 1'b1;
        new_ib_entries[j].inst  = hold_data_r[32*(int'(hold_first_r) + j) +: 32];
        new_ib_entries[j].PC    = hold_base_r + 32'(4 * (int'(hold_first_r) + j));
        new_ib_entries[j].NPC   = hold_base_r + 32'(4 * (int'(hold_first_r) + j + 1));
      end else begin
        new_ib_entries[j] = '0;
      end
    end
  end

  // Fetch sequencing: request, wait for matching epoch, hold until credit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_FETCH;
      fetch_pc_r   <= RESET_PC;
      epoch_r      <= 1'b0;
      hold_data_r  <= '0;
      hold_base_r  <= 32'h0;
      hold_first_r <= '0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
      case (state_r)
        S_FETCH: state_r <= S_FETCH;
        S_WAIT: begin
          // The outstanding request becomes stale; a response arriving in
          // this same cycle is already stale and is dropped here.
          epoch_r <= ~epoch_r;
          if (icache.icache_resp_valid) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_HOLD:  state_r <= S_FETCH;
        default: state_r <= S_FETCH;
      endcase
    end else begin
      case (state_r)
        S_FETCH: begin
          if (icache.icache_req_ready) begin
            state_r <= S_WAIT;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (icache.icache_resp_valid) begin
            if (icache.icache_resp_epoch == epoch_r) begin
              hold_data_r  <= icache.icache_resp_data;
              hold_base_r  <= block_base_s;
              hold_first_r <= fetch_pc_r[BLK_BITS-1:2];
              state_r      <= S_HOLD;
            end else begin
              state_r <= S_FETCH;
            end
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (push_s) begin
            fetch_pc_r <= hold_base_r + BLK_BYTES;
            state_r    <= S_FETCH;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: state_r <= S_FETCH;
      endcase
    end
  end

endmodule
